// File: rtl/nd_stream_fifo_bridge_pkg.sv
// -----------------------------------------------------------------------------
// nd_stream_fifo_bridge_pkg
// Shared project constants for the nd-stream output stage: the overflow
// ERRORCODE word, the default stream width and the bridge state encodings.
// Optional feature macro used by importers: NDFIFO_OVERFLOW_RECOVER_EN.
// -----------------------------------------------------------------------------
package nd_stream_fifo_bridge_pkg;

  localparam int          WDTH_DEF      = 32;
  localparam logic [31:0] ERRORCODE_DEF = 32'hFFFF_FFFF;

  // RUN: normal streaming. HALT: terminal error state (baseline build).
  // PEND_ERR: waiting for a free slot to queue ERRORCODE (recover build).
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HALT     = 2'd1,
    PEND_ERR = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/nd_stream_fifo_bridge_mem.sv
// -----------------------------------------------------------------------------
// nd_fifo_mem
// Dual-pointer circular RAM, DEPTH x WDTH. Registered write, asynchronous
// read at rd_ptr so an empty FIFO falls through with one register stage.
// Ports:
//   clk     - clock
//   wr_en   - write strobe
//   wr_ptr  - write address
//   wr_data - write word
//   rd_ptr  - read address
//   rd_data - word stored at rd_ptr (combinational)
// Macro: none (NDFIFO_OVERFLOW_RECOVER_EN only affects the top level).
// -----------------------------------------------------------------------------
module nd_fifo_mem #(
  parameter int WDTH      = 32,
  parameter int DEPTH     = 64,
  parameter int LOG_DEPTH = 6
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [LOG_DEPTH-1:0] wr_ptr,
  input  logic [WDTH-1:0]      wr_data,
  input  logic [LOG_DEPTH-1:0] rd_ptr,
  output logic [WDTH-1:0]      rd_data
);

  logic [WDTH-1:0] mem_r [DEPTH];

  // Storage array write port; contents are not reset (pointers gate validity).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr];

endmodule

// File: rtl/nd_stream_fifo_bridge.sv
// -----------------------------------------------------------------------------
// nd_stream_fifo_bridge
// Buffers the non-stallable upstream nd stream in a circular FIFO and presents
// it as a valid/ready stream. Overflow sets a sticky error, counts dropped
// words (saturating) and emits the ERRORCODE word.
// Ports:
//   clk, reset (async, active-high)
//   in_data / in_nd     - upstream word and new-data strobe
//   out_data / out_valid / out_ready - downstream valid/ready stream
//   error               - sticky overflow flag
//   dropped             - saturating count of discarded words
// Macro NDFIFO_OVERFLOW_RECOVER_EN:
//   undefined - overflow halts the bridge, which then outputs ERRORCODE forever
//   defined   - overflow queues one ERRORCODE word into the FIFO and resumes
// -----------------------------------------------------------------------------
module nd_stream_fifo_bridge
  import nd_stream_fifo_bridge_pkg::*;
#(
  parameter int              WDTH      = WDTH_DEF,
  parameter int              DEPTH     = 64,
  parameter int              LOG_DEPTH = 6,
  parameter logic [WDTH-1:0] ERRORCODE = WDTH'(ERRORCODE_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WDTH-1:0] in_data,
  input  logic            in_nd,
  output logic [WDTH-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            error,
  output logic [15:0]     dropped
);

  localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

  bridge_state_e        state_r, state_s;
  logic [LOG_DEPTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [LOG_DEPTH:0]   count_r;
  logic                 error_r;
  logic [15:0]          dropped_r;

  logic                 has_data_s, full_s;
  logic                 rd_fire_s, slot_s, wr_en_s, ovf_s, drop_inc_s;
  logic [WDTH-1:0]      wr_data_s, head_s;

  assign has_data_s = (count_r != '0);
  assign full_s     = (count_r == CNT_FULL);

  nd_fifo_mem #(
    .WDTH      (WDTH),
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_ptr  (wr_ptr_r),
    .wr_data (wr_data_s),
    .rd_ptr  (rd_ptr_r),
    .rd_data (head_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN: begin
        if (ovf_s) begin
`ifdef NDFIFO_OVERFLOW_RECOVER_EN
          state_s = PEND_ERR;
`else
          state_s = HALT;
`endif
        end else begin
          state_s = RUN;
        end
      end
      HALT: state_s = HALT;
`ifdef NDFIFO_OVERFLOW_RECOVER_EN
      PEND_ERR: begin
        // ERRORCODE goes in on the first cycle with a slot; then resume.
        if (slot_s) begin
          state_s = RUN;
        end else begin
          state_s = PEND_ERR;
        end
      end
`endif
      default: state_s = RUN;
    endcase
  end

  // Output and FIFO-port control decode.
  always_comb begin
    out_valid  = 1'b0;
    out_data   = '0;
    rd_fire_s  = 1'b0;
    slot_s     = 1'b0;
    wr_en_s    = 1'b0;
    wr_data_s  = in_data;
    ovf_s      = 1'b0;
    drop_inc_s = 1'b0;
    case (state_r)
      RUN: begin
        out_valid  = has_data_s;
        out_data   = has_data_s ? head_s : '0;
        rd_fire_s  = has_data_s & out_ready;
        // A full FIFO still accepts a word when a read frees a slot this cycle.
        slot_s     = ~full_s | rd_fire_s;
        wr_en_s    = in_nd & slot_s;
        ovf_s      = in_nd & ~slot_s;
        drop_inc_s = in_nd & ~slot_s;
      end
      HALT: begin
        out_valid = 1'b1;
        out_data  = ERRORCODE;
      end
`ifdef NDFIFO_OVERFLOW_RECOVER_EN
      PEND_ERR: begin
        out_valid  = has_data_s;
        out_data   = has_data_s ? head_s : '0;
        rd_fire_s  = has_data_s & out_ready;
        slot_s     = ~full_s | rd_fire_s;
        // ERRORCODE owns the write port; any upstream word this cycle is lost.
        wr_en_s    = slot_s;
        wr_data_s  = ERRORCODE;
        drop_inc_s = in_nd;
      end
`endif
      default: begin
        out_valid = 1'b0;
        out_data  = '0;
      end
    endcase
  end

  // Pointers, occupancy, sticky error and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      error_r   <= 1'b0;
      dropped_r <= 16'h0000;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, rd_fire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (ovf_s) begin
        error_r <= 1'b1;
      end
      if (drop_inc_s && (dropped_r != 16'hFFFF)) begin
        dropped_r <= dropped_r + 16'd1;
      end
    end
  end

  assign error   = error_r;
  assign dropped = dropped_r;

endmodule

// File: tb/tb_nd_stream_fifo_bridge.sv
// Directed bench for nd_stream_fifo_bridge. Inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_nd_stream_fifo_bridge;

  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_nd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        error;
  logic [15:0] dropped;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nd_stream_fifo_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_nd     (in_nd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .error     (error),
    .dropped   (dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_w;
    reset = 1'b1; in_nd = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid",   32'(out_valid), 32'h0);
    chk("rst_data",    out_data,       32'h0);
    chk("rst_error",   32'(error),     32'h0);
    chk("rst_dropped", 32'(dropped),   32'h0);
    reset = 1'b0;

    // Three-word burst with the consumer always ready.
    out_ready = 1'b1;
    chk("t1_idle_valid", 32'(out_valid), 32'h0);
    in_nd = 1'b1; in_data = 32'h11; cyc();
    chk("t1_valid_n1", 32'(out_valid), 32'h1);
    chk("t1_d11", out_data, 32'h11);
    in_data = 32'h22; cyc();
    chk("t1_d22", out_data, 32'h22);
    in_data = 32'h33; cyc();
    chk("t1_d33", out_data, 32'h33);
    in_nd = 1'b0; cyc();
    chk("t1_empty", 32'(out_valid), 32'h0);
    chk("t1_error", 32'(error), 32'h0);

    // Fill to 64, then write and read together while full: no overflow.
    out_ready = 1'b0; in_nd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 32'(i); cyc();
    end
    chk("t2_full_valid", 32'(out_valid), 32'h1);
    chk("t2_full_head",  out_data,       32'h0);
    in_data = 32'h40; out_ready = 1'b1; cyc();
    in_nd = 1'b0;
    chk("t2_no_drop",  32'(dropped), 32'h0);
    chk("t2_no_error", 32'(error),   32'h0);
    for (int i = 1; i <= 64; i++) begin
      exp_w = (i == 64) ? 32'h40 : 32'(i);
      chk($sformatf("t2_drain_%0d", i), out_data, exp_w);
      cyc();
    end
    chk("t2_drained", 32'(out_valid), 32'h0);

    // Overflow: full FIFO, consumer stalled, one more word.
    out_ready = 1'b0; in_nd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 32'(i); cyc();
    end
    in_data = 32'hAB; cyc();
    in_nd = 1'b0;
    chk("t3_dropped", 32'(dropped),   32'h1);
    chk("t3_error",   32'(error),     32'h1);
    chk("t3_valid",   32'(out_valid), 32'h1);
`ifdef NDFIFO_OVERFLOW_RECOVER_EN
    chk("t3_head", out_data, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      exp_w = (i == 64) ? ERR : 32'(i);
      chk($sformatf("t3_drain_%0d", i), out_data, exp_w);
      cyc();
    end
    chk("t3_drained", 32'(out_valid), 32'h0);
    in_nd = 1'b1; in_data = 32'h55; cyc();
    in_nd = 1'b0;
    chk("t3_v55", 32'(out_valid), 32'h1);
    chk("t3_d55", out_data, 32'h55);
    cyc();
    chk("t3_after55", 32'(out_valid), 32'h0);
    chk("t3_sticky", 32'(error), 32'h1);
    chk("t3_dropped_hold", 32'(dropped), 32'h1);
`else
    chk("t3_errcode", out_data, ERR);
    in_nd = 1'b1; in_data = 32'hCD; out_ready = 1'b1;
    repeat (5) cyc();
    in_nd = 1'b0; out_ready = 1'b0;
    chk("t3_halt_dropped", 32'(dropped),   32'h1);
    chk("t3_halt_data",    out_data,       ERR);
    chk("t3_halt_valid",   32'(out_valid), 32'h1);
`endif

    // Asynchronous reset in the middle of a buffered stream.
    out_ready = 1'b0; in_nd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h100 + 32'(i); cyc();
    end
    in_nd = 1'b0;
    chk("t4_pre_valid", 32'(out_valid), 32'h1);
    chk("t4_pre_error", 32'(error),     32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t4_async_valid",   32'(out_valid), 32'h0);
    chk("t4_async_error",   32'(error),     32'h0);
    chk("t4_async_dropped", 32'(dropped),   32'h0);
    chk("t4_async_data",    out_data,       32'h0);
    @(negedge clk);
    reset = 1'b0;
    in_nd = 1'b1; in_data = 32'h77; cyc();
    in_nd = 1'b0;
    chk("t4_v77", 32'(out_valid), 32'h1);
    chk("t4_d77", out_data, 32'h77);
    out_ready = 1'b1; cyc();
    chk("t4_alone", 32'(out_valid), 32'h0);

`ifdef NDFIFO_OVERFLOW_RECOVER_EN
    // Drop-counter saturation while pending with a full FIFO.
    out_ready = 1'b0; in_nd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 32'(i); cyc();
    end
    in_data = 32'hEE;
    repeat (10) cyc();
    chk("t5_dropped_10", 32'(dropped), 32'd10);
    repeat (69990) cyc();
    in_nd = 1'b0;
    chk("t5_saturated", 32'(dropped), 32'h0000_FFFF);
    chk("t5_error",     32'(error),   32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
